// File: rtl/control_sequencer.sv
// control_sequencer: hardwired fetch/execute strobe sequencer for the 32-bit System datapath
module control_sequencer #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  Clock,
   input  logic                  clear,
   input  logic [DATA_WIDTH-1:0] ir,
   input  logic                  memory_done,
   output logic                  HIout,
   output logic                  LOout,
   output logic                  Zhi_out,
   output logic                  Zlo_out,
   output logic                  PCout,
   output logic                  MDRout,
   output logic                  Inport_out,
   output logic                  Cout,
   output logic                  BAout,
   output logic                  MARin,
   output logic                  Zin,
   output logic                  PCin,
   output logic                  MDRin,
   output logic                  IRin,
   output logic                  Yin,
   output logic                  HIin,
   output logic                  LOin,
   output logic                  CONin,
   output logic                  outport_in,
   output logic                  Gra,
   output logic                  Grb,
   output logic                  Grc,
   output logic                  Rin,
   output logic                  Rout,
   output logic                  IncPC,
   output logic [4:0]            opcode,
   output logic                  Mem_Read,
   output logic                  Mem_Write,
   output logic                  Mem_enable512x32,
   output logic                  run
);
   typedef enum logic [4:0] {
      IDLE, F0, F1, F1W, F2, E3, R4, R5, I4, I5, L4, L5, L6, L7, S6, S7, HALT
   } state_t;
   state_t st, nxt;
   logic [4:0] op;
   logic       is_r, is_i, is_ld, is_st, is_mfhi, is_mflo, is_halt, is_mem, is_mv;
   logic       unused_ir;
   assign op        = ir[DATA_WIDTH-1 -: 5];
   assign unused_ir = ^ir[DATA_WIDTH-6:0];
   assign is_r      = op inside {5'b00011, 5'b00100, 5'b00101, 5'b00110};
   assign is_i      = op inside {5'b01100, 5'b01101, 5'b01110};
   assign is_ld     = op == 5'b00000;
   assign is_st     = op == 5'b00010;
   assign is_mfhi   = op == 5'b11000;
   assign is_mflo   = op == 5'b11001;
   assign is_halt   = op == 5'b11011;
   assign is_mem    = is_ld | is_st;
   assign is_mv     = is_mfhi | is_mflo;
   always_comb begin
      case (st)
         IDLE:    nxt = F0;
         F0:      nxt = F1;
         F1, F1W: nxt = memory_done ? F2 : F1W;
         F2:      nxt = E3;
         E3:      nxt = is_r ? R4 : is_i ? I4 : is_mem ? L4 : is_halt ? HALT : F0;
         R4:      nxt = R5;
         I4:      nxt = I5;
         L4:      nxt = L5;
         L5:      nxt = is_st ? S6 : L6;
         L6:      nxt = memory_done ? L7 : L6;
         S6:      nxt = S7;
         S7:      nxt = memory_done ? F0 : S7;
         R5, I5, L7: nxt = F0;
         HALT:    nxt = HALT;
         default: nxt = IDLE;
      endcase
   end
   always_ff @(posedge Clock)
      st <= clear ? IDLE : nxt;
   assign run              = !(st inside {IDLE, HALT});
   assign PCout            = st == F0;
   assign IncPC            = st == F0;
   assign MARin            = st inside {F0, L5};
   assign Zin              = st inside {F0, R4, I4, L4};
   assign Zlo_out          = st inside {F1, F1W, R5, I5, L5};
   assign PCin             = st == F1;
   assign MDRin            = st inside {F1, F1W, L6, S6};
   assign Mem_Read         = st inside {F1, F1W, L6};
   assign Mem_enable512x32 = st inside {F1, F1W, L6, S7};
   assign Mem_Write        = st == S7;
   assign MDRout           = st inside {F2, L7};
   assign IRin             = st == F2;
   assign Grb              = st == E3 && (is_r || is_i || is_mem);
   assign Yin              = Grb;
   assign BAout            = st == E3 && is_mem;
   assign Rout             = (st == E3 && (is_r || is_i)) || st inside {R4, S6};
   assign HIout            = st == E3 && is_mfhi;
   assign LOout            = st == E3 && is_mflo;
   assign Gra              = (st == E3 && is_mv) || st inside {R5, I5, L7, S6};
   assign Rin              = (st == E3 && is_mv) || st inside {R5, I5, L7};
   assign Grc              = st == R4;
   assign Cout             = st inside {I4, L4};
   assign opcode           = st == R4 ? op :
                             st == I4 ? (op == 5'b01101 ? 5'b00101 : op == 5'b01110 ? 5'b00110 : 5'b00011) :
                             st == L4 ? 5'b00011 : 5'b00000;
   assign Zhi_out          = 1'b0;
   assign Inport_out       = 1'b0;
   assign HIin             = 1'b0;
   assign LOin             = 1'b0;
   assign CONin            = 1'b0;
   assign outport_in       = 1'b0;
endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: scoreboard bench replaying per-cycle expected strobe vectors
module tb_control_sequencer;
   logic Clock, clear, memory_done;
   logic [31:0] ir;
   logic HIout, LOout, Zhi_out, Zlo_out, PCout, MDRout, Inport_out, Cout, BAout;
   logic MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin, CONin, outport_in;
   logic Gra, Grb, Grc, Rin, Rout, IncPC, Mem_Read, Mem_Write, Mem_enable512x32, run;
   logic [4:0] opcode;
   control_sequencer #(.DATA_WIDTH(32)) dut (
      .Clock(Clock), .clear(clear), .ir(ir), .memory_done(memory_done),
      .HIout(HIout), .LOout(LOout), .Zhi_out(Zhi_out), .Zlo_out(Zlo_out), .PCout(PCout),
      .MDRout(MDRout), .Inport_out(Inport_out), .Cout(Cout), .BAout(BAout),
      .MARin(MARin), .Zin(Zin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin),
      .HIin(HIin), .LOin(LOin), .CONin(CONin), .outport_in(outport_in),
      .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .IncPC(IncPC),
      .opcode(opcode), .Mem_Read(Mem_Read), .Mem_Write(Mem_Write),
      .Mem_enable512x32(Mem_enable512x32), .run(run)
   );
   localparam logic [33:0] HO = 34'd1 << 0, LO = 34'd1 << 1, ZLO = 34'd1 << 3, PCO = 34'd1 << 4,
      MDRO = 34'd1 << 5, CO = 34'd1 << 7, BAO = 34'd1 << 8, MARI = 34'd1 << 9, ZI = 34'd1 << 10,
      PCI = 34'd1 << 11, MDRI = 34'd1 << 12, IRI = 34'd1 << 13, YI = 34'd1 << 14,
      GRA = 34'd1 << 19, GRB = 34'd1 << 20, GRC = 34'd1 << 21, RIN = 34'd1 << 22, ROUT = 34'd1 << 23,
      INC = 34'd1 << 24, MRD = 34'd1 << 25, MWR = 34'd1 << 26, MEN = 34'd1 << 27, RUN = 34'd1 << 28;
   typedef struct {
      logic [33:0] exp;
      logic        md;
      logic        clr;
      logic [31:0] ir;
   } rec_t;
   rec_t q[$];
   rec_t r;
   logic [31:0] cur_ir;
   logic [33:0] obs;
   int checks = 0, errors = 0, cyc = 0;
   assign obs = {opcode, run, Mem_enable512x32, Mem_Write, Mem_Read, IncPC, Rout, Rin, Grc, Grb, Gra,
                 outport_in, CONin, LOin, HIin, Yin, IRin, MDRin, PCin, Zin, MARin, BAout, Cout,
                 Inport_out, MDRout, PCout, Zlo_out, Zhi_out, LOout, HIout};
   initial Clock = 1'b0;
   always #5 Clock = ~Clock;
   task automatic check(input string tag, input logic [33:0] got, input logic [33:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask
   function automatic logic [33:0] opf(input logic [4:0] o);
      return {o, 29'd0};
   endfunction
   task automatic push(input logic [33:0] e, input logic m, input logic c);
      q.push_back('{exp: e, md: m, clr: c, ir: cur_ir});
   endtask
   task automatic fetch(input int stall);
      push(PCO | INC | MARI | ZI | RUN, 1'b1, 1'b0);
      push(ZLO | PCI | MDRI | MRD | MEN | RUN, stall == 0, 1'b0);
      for (int i = 0; i < stall; i++) push(ZLO | MDRI | MRD | MEN | RUN, i == stall - 1, 1'b0);
      push(MDRO | IRI | RUN, 1'b1, 1'b0);
   endtask
   task automatic alu(input logic [31:0] ins, input logic imm, input logic [4:0] o, input int stall);
      cur_ir = ins;
      fetch(stall);
      push(GRB | ROUT | YI | RUN, 1'b1, 1'b0);
      push((imm ? CO : GRC | ROUT) | ZI | RUN | opf(o), 1'b1, 1'b0);
      push(ZLO | GRA | RIN | RUN, 1'b1, 1'b0);
   endtask
   task automatic addr_calc(input logic [31:0] ins);
      cur_ir = ins;
      fetch(0);
      push(GRB | BAO | YI | RUN, 1'b1, 1'b0);
      push(CO | ZI | RUN | opf(5'b00011), 1'b1, 1'b0);
      push(ZLO | MARI | RUN, 1'b1, 1'b0);
   endtask
   initial begin
      clear = 1'b1;
      memory_done = 1'b1;
      ir = '0;
      cur_ir = '0;
      push('0, 1'b1, 1'b1);
      push('0, 1'b1, 1'b1);
      push('0, 1'b1, 1'b0);
      cur_ir = 32'hC300_0000;
      fetch(0);
      push(GRA | HO | RIN | RUN, 1'b1, 1'b0);
      cur_ir = 32'hCB80_0000;
      fetch(0);
      push(GRA | LO | RIN | RUN, 1'b1, 1'b0);
      alu(32'h1800_0000, 1'b0, 5'b00011, 3);
      alu(32'h2000_0000, 1'b0, 5'b00100, 0);
      alu(32'h3000_0000, 1'b0, 5'b00110, 0);
      alu(32'h6000_0000, 1'b1, 5'b00011, 0);
      alu(32'h6800_0000, 1'b1, 5'b00101, 1);
      alu(32'h7000_0000, 1'b1, 5'b00110, 0);
      addr_calc(32'h0000_0000);
      push(MRD | MEN | MDRI | RUN, 1'b0, 1'b0);
      push(MRD | MEN | MDRI | RUN, 1'b0, 1'b0);
      push(MRD | MEN | MDRI | RUN, 1'b1, 1'b0);
      push(MDRO | GRA | RIN | RUN, 1'b1, 1'b0);
      addr_calc(32'h1000_0000);
      push(GRA | ROUT | MDRI | RUN, 1'b1, 1'b0);
      push(MWR | MEN | RUN, 1'b0, 1'b0);
      push(MWR | MEN | RUN, 1'b1, 1'b0);
      cur_ir = 32'hD800_0000;
      fetch(0);
      push(RUN, 1'b1, 1'b0);
      for (int i = 0; i < 10; i++) push('0, i % 2 == 0, 1'b0);
      push('0, 1'b1, 1'b1);
      push('0, 1'b1, 1'b0);
      addr_calc(32'h0000_0000);
      push(MRD | MEN | MDRI | RUN, 1'b0, 1'b1);
      push('0, 1'b0, 1'b0);
      cur_ir = 32'hC300_0000;
      fetch(0);
      push(GRA | HO | RIN | RUN, 1'b1, 1'b0);
      @(posedge Clock);
      while (q.size() > 0) begin
         r = q.pop_front();
         #1;
         clear = r.clr;
         memory_done = r.md;
         ir = r.ir;
         #1;
         check($sformatf("cyc%0d", cyc), obs, r.exp);
         check($sformatf("bus%0d", cyc),
               34'($countones({HIout, LOout, Zhi_out, Zlo_out, PCout, MDRout, Inport_out, Cout, BAout, Rout}) <= 1),
               34'd1);
         cyc++;
         @(posedge Clock);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
